// File: rtl/spi_master_param.sv
// spi_master_param
//   Full-duplex SPI master with a configurable word width, SCK divider, SPI
//   mode (CPOL/CPHA), bit order and number of chip selects. One transfer
//   shifts tx_data out on mosi and assembles the bits captured from miso
//   into rx_data.
//
// Ports
//   clk, rst  system clock (rising edge) and synchronous active-high reset
//   start     transfer request, taken only while ready=1
//   cs_sel    slave index, latched with start (out-of-range selects nothing)
//   tx_data   word to send, latched with start
//   ready     idle and able to accept start
//   rx_data   last complete received word, updated together with done
//   done      one-cycle pulse at the end of a transfer
//   sck       SPI clock, idles at CPOL
//   mosi      serial data out
//   miso      serial data in
//   cs_n      active-low chip selects, one per slave
module spi_master_param #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int NUM_CS    = 1,
  localparam int CS_W     = ($clog2(NUM_CS) > 0) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int DIV_W  = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);
  localparam logic [HALF_W-1:0] HALF_PEN  = HALF_W'(2 * DATA_W - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;

  logic lead;
  logic trail;
  logic last_trail;

  // Bit currently at the outgoing end of the shift register.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) return {w[DATA_W-2:0], 1'b0};
    else           return {1'b0, w[DATA_W-1:1]};
  endfunction

  // Incoming bits enter at the end opposite to where they finish, so after
  // DATA_W samples the word sits in natural bit order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                input logic b);
    if (MSB_FIRST) return {w[DATA_W-2:0], b};
    else           return {b, w[DATA_W-1:1]};
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // The final trailing edge closes the last bit; nothing follows it.
  assign last_trail = (half_q == HALF_PEN);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    lead      = 1'b0;
    trail     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          div_d   = '0;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          cs_n_d  = ~cs_decode(cs_sel);
          sck_d   = CPOL;
          if (!CPHA) mosi_d = first_bit(tx_data);
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          half_d  = '0;
          lead    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_q == HALF_LAST) begin
            state_d = ST_HOLD;
          end else begin
            half_d = half_q + 1'b1;
            // Even half-periods start on a leading edge, odd ones on a trailing edge.
            if (half_q[0]) lead  = 1'b1;
            else           trail = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d   = ST_IDLE;
          div_d     = '0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          cs_n_d    = '1;
          mosi_d    = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (lead || trail) sck_d = ~sck_q;

    if (CPHA ? trail : lead) rx_sh_d = shift_in(rx_sh_q, miso);

    if (CPHA && lead) begin
      mosi_d  = first_bit(tx_sh_q);
      tx_sh_d = shift_out(tx_sh_q);
    end

    if (!CPHA && trail && !last_trail) begin
      tx_sh_d = shift_out(tx_sh_q);
      mosi_d  = first_bit(shift_out(tx_sh_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      half_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cs_n_q    <= '1;
      sck_q     <= CPOL;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: several configurations side by side.
//   u_m0           mode 0, 8 bit, CLK_DIV=2, MSB first, miso looped to mosi
//   g_mode[1..3]   modes 1..3 against a small behavioural slave returning 0x3C
//   u_m4           NUM_CS=4, loopback
//   u_m5           NUM_CS=3, loopback
//   u_m6           16 bit, CLK_DIV=1, LSB first, loopback
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  start_v = '0;
  logic [7:0]  tx8 = '0;
  logic [15:0] tx16 = '0;
  logic [1:0]  csel = '0;

  wire [6:0]        ready_v;
  wire [6:0]        done_v;
  wire [6:0]        sck_v;
  wire [6:0]        mosi_v;
  wire [6:0][15:0]  rx_v;
  wire [6:0][3:0]   csn_v;
  wire [3:1][7:0]   srx_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0),
                     .MSB_FIRST(1'b1), .NUM_CS(1)) u_m0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .cs_sel(csel[0]), .tx_data(tx8),
    .ready(ready_v[0]), .rx_data(rx_v[0][7:0]), .done(done_v[0]), .sck(sck_v[0]),
    .mosi(mosi_v[0]), .miso(mosi_v[0]), .cs_n(csn_v[0][0]));
  assign rx_v[0][15:8]  = '0;
  assign csn_v[0][3:1]  = '1;

  for (genvar g = 1; g < 4; g++) begin : g_mode
    localparam bit GPOL = (g >= 2);
    localparam bit GPHA = ((g % 2) == 1);
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic       s_miso = 1'b0;
    logic       p_sck = GPOL;
    logic       p_csn = 1'b1;

    spi_master_param #(.DATA_W(8), .CLK_DIV(2), .CPOL(GPOL), .CPHA(GPHA),
                       .MSB_FIRST(1'b1), .NUM_CS(1)) u_m (
      .clk(clk), .rst(rst), .start(start_v[g]), .cs_sel(csel[0]), .tx_data(tx8),
      .ready(ready_v[g]), .rx_data(rx_v[g][7:0]), .done(done_v[g]), .sck(sck_v[g]),
      .mosi(mosi_v[g]), .miso(s_miso), .cs_n(csn_v[g][0]));
    assign rx_v[g][15:8] = '0;
    assign csn_v[g][3:1] = '1;
    assign srx_w[g]      = s_rx;

    // Slave: presents its first bit at select for CPHA=0, samples mosi on the
    // sampling edge of its mode and shifts its own word on the other edge.
    always @(csn_v[g][0] or sck_v[g]) begin
      if (p_csn === 1'b1 && csn_v[g][0] === 1'b0) begin
        s_tx = 8'h3C;
        s_rx = 8'h00;
        if (!GPHA) s_miso = s_tx[7];
      end else if (csn_v[g][0] === 1'b0 && sck_v[g] !== p_sck) begin
        if ((sck_v[g] != GPOL) ^ GPHA) begin
          s_rx = {s_rx[6:0], mosi_v[g]};
        end else if (GPHA) begin
          s_miso = s_tx[7];
          s_tx   = {s_tx[6:0], 1'b0};
        end else begin
          s_tx   = {s_tx[6:0], 1'b0};
          s_miso = s_tx[7];
        end
      end
      p_csn = csn_v[g][0];
      p_sck = sck_v[g];
    end
  end

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u_m4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .cs_sel(csel), .tx_data(tx8),
    .ready(ready_v[4]), .rx_data(rx_v[4][7:0]), .done(done_v[4]), .sck(sck_v[4]),
    .mosi(mosi_v[4]), .miso(mosi_v[4]), .cs_n(csn_v[4]));
  assign rx_v[4][15:8] = '0;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(3)) u_m5 (
    .clk(clk), .rst(rst), .start(start_v[5]), .cs_sel(csel), .tx_data(tx8),
    .ready(ready_v[5]), .rx_data(rx_v[5][7:0]), .done(done_v[5]), .sck(sck_v[5]),
    .mosi(mosi_v[5]), .miso(mosi_v[5]), .cs_n(csn_v[5][2:0]));
  assign rx_v[5][15:8] = '0;
  assign csn_v[5][3]   = 1'b1;

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1'b0), .NUM_CS(1)) u_m6 (
    .clk(clk), .rst(rst), .start(start_v[6]), .cs_sel(csel[0]), .tx_data(tx16),
    .ready(ready_v[6]), .rx_data(rx_v[6]), .done(done_v[6]), .sck(sck_v[6]),
    .mosi(mosi_v[6]), .miso(mosi_v[6]), .cs_n(csn_v[6][0]));
  assign csn_v[6][3:1] = '1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one transfer on instance idx. Cycle c counts clock edges after the
  // accepting edge; the value looked at on negedge c is what edge T0+c samples.
  task automatic xfer(input int idx, input logic [15:0] tx, input logic [1:0] cs,
                      input bit now, input int poke,
                      output int lat, output int rises, output int cslow,
                      output logic [3:0] csseen, output logic [15:0] mseq);
    logic prev;
    lat = -1; rises = 0; cslow = 0; csseen = '0; mseq = '0;
    if (!now) @(negedge clk);
    check($sformatf("ready_before%0d", idx), ready_v[idx], 1);
    tx8 = tx[7:0];
    tx16 = tx;
    csel = cs;
    start_v[idx] = 1'b1;
    prev = sck_v[idx];
    @(negedge clk);
    start_v[idx] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (!prev && sck_v[idx]) begin
        rises++;
        mseq = {mseq[14:0], mosi_v[idx]};
      end
      prev = sck_v[idx];
      if (csn_v[idx] != 4'hF) begin
        cslow++;
        csseen = csseen | ~csn_v[idx];
      end
      if (done_v[idx]) begin
        lat = c;
        break;
      end
      start_v[idx] = (c == poke);
      @(negedge clk);
    end
    start_v[idx] = 1'b0;
  endtask

  int          lat, rises, cslow, ndone;
  logic [3:0]  csseen;
  logic [15:0] mseq;

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("rst_ready%0d", i), ready_v[i], 1);
      check($sformatf("rst_done%0d", i),  done_v[i], 0);
      check($sformatf("rst_rx%0d", i),    rx_v[i], 0);
      check($sformatf("rst_sck%0d", i),   sck_v[i], (i == 2 || i == 3));
      check($sformatf("rst_csn%0d", i),   csn_v[i], 4'hF);
      check($sformatf("rst_mosi%0d", i),  mosi_v[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Mode 0 loopback
    xfer(0, 16'h00A5, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t1_lat", lat, 37);
    check("t1_rises", rises, 8);
    check("t1_cslow", cslow, 36);
    check("t1_csseen", csseen, 4'b0001);
    check("t1_rx", rx_v[0], 16'h00A5);
    check("t1_mosi_seq", mseq[7:0], 8'hA5);
    check("t1_ready_done", ready_v[0], 1);
    check("t1_sck_idle", sck_v[0], 0);
    check("t1_mosi_done", mosi_v[0], 0);

    xfer(0, 16'h0001, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t1_msb_order", mseq[7:0], 8'h01);
    check("t1_rx_01", rx_v[0], 16'h0001);

    // Modes 1..3 against the slave
    for (int g = 1; g < 4; g++) begin
      xfer(g, 16'h00C3, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
      check($sformatf("t2_lat_m%0d", g), lat, 37);
      check($sformatf("t2_rises_m%0d", g), rises, 8);
      check($sformatf("t2_rx_m%0d", g), rx_v[g], 16'h003C);
      check($sformatf("t2_slave_m%0d", g), srx_w[g], 8'hC3);
      check($sformatf("t2_sck_idle_m%0d", g), sck_v[g], (g >= 2));
    end

    // start pulsed mid-transfer must be ignored
    xfer(0, 16'h005A, 2'd0, 1'b0, 10, lat, rises, cslow, csseen, mseq);
    check("t3_poke_lat", lat, 37);
    check("t3_poke_rx", rx_v[0], 16'h005A);
    @(negedge clk);
    check("t3_poke_idle_rdy", ready_v[0], 1);
    check("t3_poke_idle_csn", csn_v[0], 4'hF);

    // back-to-back: second start issued on the done cycle
    xfer(0, 16'h003C, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t3_b2b_lat1", lat, 37);
    check("t3_b2b_cs_gap", csn_v[0], 4'hF);
    xfer(0, 16'h00C6, 2'd0, 1'b1, -1, lat, rises, cslow, csseen, mseq);
    check("t3_b2b_lat2", lat, 37);
    check("t3_b2b_cslow2", cslow, 36);
    check("t3_b2b_rx2", rx_v[0], 16'h00C6);

    // chip-select decode
    xfer(4, 16'h005A, 2'd2, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t4_cs2_seen", csseen, 4'b0100);
    check("t4_cs2_lat", lat, 37);
    check("t4_cs2_rx", rx_v[4], 16'h005A);
    xfer(5, 16'h0011, 2'd3, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t4_oor_seen", csseen, 4'b0000);
    check("t4_oor_cslow", cslow, 0);
    check("t4_oor_lat", lat, 37);
    check("t4_oor_rx", rx_v[5], 16'h0011);

    // 16 bit, LSB first, CLK_DIV=1
    xfer(6, 16'h8001, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t6_lat", lat, 35);
    check("t6_rises", rises, 16);
    check("t6_cslow", cslow, 34);
    check("t6_rx", rx_v[6], 16'h8001);
    check("t6_mosi_seq", mseq, 16'h8001);
    xfer(6, 16'h0001, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t6_lsb_first", mseq, 16'h8000);
    check("t6_rx_0001", rx_v[6], 16'h0001);
    xfer(6, 16'h00F0, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t6_seq_00f0", mseq, 16'h0F00);
    check("t6_rx_00f0", rx_v[6], 16'h00F0);

    // reset during the 4th bit of a transfer
    @(negedge clk);
    tx8 = 8'h96;
    csel = 2'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_busy", ready_v[0], 0);
    check("t5_cs_active", csn_v[0], 4'hE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_csn", csn_v[0], 4'hF);
    check("t5_sck", sck_v[0], 0);
    check("t5_ready", ready_v[0], 1);
    check("t5_rx", rx_v[0], 0);
    check("t5_done", done_v[0], 0);
    check("t5_mosi", mosi_v[0], 0);
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("t5_no_done", ndone, 0);
    xfer(0, 16'h0081, 2'd0, 1'b0, -1, lat, rises, cslow, csseen, mseq);
    check("t5_after_lat", lat, 37);
    check("t5_after_rx", rx_v[0], 16'h0081);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
